mcpu_ctrl_fsm: RTL
==================

// Module: mcpu_ctrl_fsm
// PURPOSE
//  Multi-cycle MIPS control unit: sequences IF/ID/EX/MEM/WB over a shared memory port and shared ALU.
//  Same ISA as the single-cycle controller: add sub and or xor nor slt srl jr jalr lui lw sw beq bne j addi andi ori slti xori jal.
//  Stalls on MIO_ready and flags illegal opcodes. Sits between the IR/zero flag and the multi-cycle datapath muxes/enables.
// PARAMETERS
//  ALU_W      3   ALU_Control width; codes and=0 or=1 add=2 xor=3 nor=4 srl=5 sub=6 slt=7, zero-extended to ALU_W
//  WAIT_LIMIT 0   max consecutive MIO_ready=0 cycles in IF/MEM before bus_err; 0 = wait forever
//  CNT_W      8   width of wait counter; WAIT_LIMIT must be < 2**CNT_W
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      synchronous reset, active low
//  OPcode       in   6      IR[31:26], valid from ID onward
//  Fun          in   6      IR[5:0]
//  zero         in   1      ALU zero flag
//  MIO_ready    in   1      memory/IO access complete this cycle
//  PCWrite      out  1      PC load enable
//  IorD         out  1      mem addr: 0=PC, 1=ALUOut
//  MemRead      out  1      memory read request
//  mem_w        out  1      memory write request
//  IRWrite      out  1      IR load enable
//  RegDst       out  2      00=rt 01=rd 10=$31
//  DatatoReg    out  2      00=ALUOut 01=MDR 10=lui imm 11=PC
//  RegWrite     out  1      register file write enable
//  ALUSrcA      out  1      0=PC 1=rs
//  ALUSrcB      out  2      00=rt 01=4 10=sext imm 11=sext imm<<2
//  PCSource     out  2      00=ALU 01=ALUOut 10=jump target 11=rs
//  ALU_Control  out  ALU_W  ALU operation
//  CPU_MIO      out  1      1 while IF/MEM states own the bus
//  illegal      out  1      undecodable instruction, sticky until reset
//  bus_err      out  1      WAIT_LIMIT exceeded, sticky until reset
//  state        out  4      current state (debug)
// BEHAVIOUR
//  States: IF=0 ID=1 MADR=2 MRD=3 MWB=4 MWR=5 REX=6 RWB=7 BR=8 JMP=9 IEX=10 IWB=11 JAL=12 JR=13 LUI=14 TRAP=15.
//  rst_n=0 at clk edge: state<=IF, wait cnt<=0, illegal/bus_err<=0; while rst_n=0 all outputs forced 0, state reads 0.
//  Outputs are Moore (decoded from state, OPcode, Fun), except PCWrite in BR which uses zero.
//  IF: MemRead, IorD=0, CPU_MIO, ALUSrcA=0, ALUSrcB=01, add; on MIO_ready=1: IRWrite=1, PCWrite=1 (PC+4), ->ID; else hold.
//  ID: ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut); dispatch on OPcode/Fun:
//   lw/sw->MADR; R ALU funct->REX; jr->JR; jalr->JAL; beq/bne->BR; j->JMP; jal->JAL;
//   addi/andi/ori/slti/xori->IEX; lui->LUI; anything else (incl. unknown funct)->TRAP.
//  MADR: ALUSrcA=1, ALUSrcB=10, add -> MRD(lw)/MWR(sw).
//  MRD: MemRead, IorD=1, CPU_MIO; MIO_ready=1 -> MWB, else hold. MWB: RegDst=00, DatatoReg=01, RegWrite -> IF.
//  MWR: mem_w, IorD=1, CPU_MIO; MIO_ready=1 -> IF, else hold (mem_w held high while stalled).
//  REX: ALUSrcA=1, ALUSrcB=00, ALU_Control per funct -> RWB. RWB: RegDst=01, DatatoReg=00, RegWrite -> IF.
//  IEX: ALUSrcA=1, ALUSrcB=10, ALU_Control per opcode -> IWB. IWB: RegDst=00, DatatoReg=00, RegWrite -> IF.
//  LUI: RegDst=00, DatatoReg=10, RegWrite -> IF.
//  BR: ALUSrcA=1, ALUSrcB=00, sub, PCSource=01; PCWrite = zero (beq) / ~zero (bne) -> IF.
//  JMP: PCSource=10, PCWrite -> IF. JR: PCSource=11, PCWrite -> IF.
//  JAL: RegDst=10 (jal) or 01 (jalr), DatatoReg=11 (PC already +4), RegWrite, PCSource=10 (jal)/11 (jalr), PCWrite -> IF.
//  TRAP: illegal<=1, all enables 0, stays until reset.
//  Cycles at zero wait: lw 5; R/I-ALU, sw 4; lui, branch, j, jr, jal, jalr 3. Each MIO_ready=0 cycle adds 1.
//  Wait counter: counts consecutive stalled cycles in IF/MRD/MWR, cleared on MIO_ready=1 or state change.
//   WAIT_LIMIT>0 and cnt==WAIT_LIMIT with MIO_ready=0 -> bus_err<=1, ->TRAP; cnt saturates, never wraps.
//  Unspecified outputs in a state are 0. Reset mid-stall abandons the access: next cycle is IF with mem_w=0.
// STRUCTURE
//  mcpu_defs.vh: state encodings, opcode/funct constants, ALU codes, RegDst/DatatoReg/PCSource encodings.
//  Sub-module mcpu_ctrl_decode: combinational OPcode/Fun -> next-state class + ALU_Control + illegal.
//  Top holds state reg, wait counter, sticky flags, per-state output decode.
// TESTING
//  add after reset, MIO_ready=1 -> states 0,1,6,7,0; RWB: RegWrite=1 RegDst=01; ALU_Control=2 in REX.
//  lw with MIO_ready=0 for 3 cycles in MRD -> MRD held 4 cycles, MemRead=1 IorD=1 throughout; total 8 cycles.
//  beq zero=1 -> PCWrite=1 PCSource=01 in BR; bne zero=1 -> PCWrite=0; both back to IF next cycle.
//  jal -> RegDst=10 DatatoReg=11 RegWrite=1 PCWrite=1 PCSource=10 in one cycle; jalr -> RegDst=01 PCSource=11.
//  OPcode=6'b111111 -> TRAP, illegal=1, all enables 0 for 20 cycles; rst_n=0 one edge -> IF, illegal=0.
//  WAIT_LIMIT=4, MIO_ready stuck 0 in IF -> bus_err=1, state=15 on 5th stalled edge; sw mid-stall rst_n=0 -> mem_w=0.

Source files
------------

// File: rtl/mcpu_ctrl_fsm_pkg.sv
// rtl/mcpu_ctrl_fsm_pkg.sv - state, opcode/funct, ALU and mux-select encodings for the multi-cycle controller
package mcpu_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_REX  = 4'd6,
        S_RWB  = 4'd7,
        S_BR   = 4'd8,
        S_JMP  = 4'd9,
        S_IEX  = 4'd10,
        S_IWB  = 4'd11,
        S_JAL  = 4'd12,
        S_JR   = 4'd13,
        S_LUI  = 4'd14,
        S_TRAP = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_JALR = 6'b001001;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_XOR = 3'd3;
    localparam logic [2:0] ALU_NOR = 3'd4;
    localparam logic [2:0] ALU_SRL = 3'd5;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] DTR_ALUOUT = 2'b00;
    localparam logic [1:0] DTR_MDR    = 2'b01;
    localparam logic [1:0] DTR_LUI    = 2'b10;
    localparam logic [1:0] DTR_PC     = 2'b11;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

endpackage

// File: rtl/mcpu_ctrl_fsm_if.sv
// rtl/mcpu_ctrl_fsm_if.sv - controller <-> datapath signal bundle
interface mcpu_ctrl_fsm_if #(
    parameter int ALU_W = 3
);
    logic [5:0]       OPcode;
    logic [5:0]       Fun;
    logic             zero;
    logic             MIO_ready;
    logic             PCWrite;
    logic             IorD;
    logic             MemRead;
    logic             mem_w;
    logic             IRWrite;
    logic [1:0]       RegDst;
    logic [1:0]       DatatoReg;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       PCSource;
    logic [ALU_W-1:0] ALU_Control;
    logic             CPU_MIO;
    logic             illegal;
    logic             bus_err;
    logic [3:0]       state;

    modport master (
        input  OPcode, Fun, zero, MIO_ready,
        output PCWrite, IorD, MemRead, mem_w, IRWrite, RegDst, DatatoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSource, ALU_Control, CPU_MIO, illegal, bus_err, state
    );

    modport slave (
        output OPcode, Fun, zero, MIO_ready,
        input  PCWrite, IorD, MemRead, mem_w, IRWrite, RegDst, DatatoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSource, ALU_Control, CPU_MIO, illegal, bus_err, state
    );
endinterface

// File: rtl/mcpu_ctrl_fsm_decode.sv
// rtl/mcpu_ctrl_fsm_decode.sv - OPcode/Fun to post-ID state, ALU operation and illegal flag
module mcpu_ctrl_fsm_decode
    import mcpu_ctrl_fsm_pkg::*;
#(
    parameter int ALU_W = 3
) (
    input  logic [5:0]       opcode,
    input  logic [5:0]       fun,
    output state_t           dispatch,
    output logic [ALU_W-1:0] alu_ctrl,
    output logic             illegal
);

    logic [2:0] alu3;

    always_comb begin
        dispatch = S_TRAP;
        alu3     = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (fun)
                    F_ADD:   begin dispatch = S_REX; alu3 = ALU_ADD; end
                    F_SUB:   begin dispatch = S_REX; alu3 = ALU_SUB; end
                    F_AND:   begin dispatch = S_REX; alu3 = ALU_AND; end
                    F_OR:    begin dispatch = S_REX; alu3 = ALU_OR;  end
                    F_XOR:   begin dispatch = S_REX; alu3 = ALU_XOR; end
                    F_NOR:   begin dispatch = S_REX; alu3 = ALU_NOR; end
                    F_SLT:   begin dispatch = S_REX; alu3 = ALU_SLT; end
                    F_SRL:   begin dispatch = S_REX; alu3 = ALU_SRL; end
                    F_JR:    dispatch = S_JR;
                    // jalr shares the link-and-jump state with jal
                    F_JALR:  dispatch = S_JAL;
                    default: dispatch = S_TRAP;
                endcase
            end
            OP_LW, OP_SW:   dispatch = S_MADR;
            OP_BEQ, OP_BNE: dispatch = S_BR;
            OP_J:           dispatch = S_JMP;
            OP_JAL:         dispatch = S_JAL;
            OP_ADDI:        begin dispatch = S_IEX; alu3 = ALU_ADD; end
            OP_ANDI:        begin dispatch = S_IEX; alu3 = ALU_AND; end
            OP_ORI:         begin dispatch = S_IEX; alu3 = ALU_OR;  end
            OP_SLTI:        begin dispatch = S_IEX; alu3 = ALU_SLT; end
            OP_XORI:        begin dispatch = S_IEX; alu3 = ALU_XOR; end
            OP_LUI:         dispatch = S_LUI;
            default:        dispatch = S_TRAP;
        endcase
    end

    assign alu_ctrl = ALU_W'(alu3);
    assign illegal  = (dispatch == S_TRAP);

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// rtl/mcpu_ctrl_fsm.sv - multi-cycle MIPS control FSM with bus-stall timeout and sticky fault flags
module mcpu_ctrl_fsm
    import mcpu_ctrl_fsm_pkg::*;
#(
    parameter int ALU_W      = 3,
    parameter int WAIT_LIMIT = 0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mcpu_ctrl_fsm_if.master  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(WAIT_LIMIT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;

    state_t           dec_dispatch;
    logic [ALU_W-1:0] dec_alu;
    logic             dec_illegal;

    logic             stalled;
    logic             limit_hit;

    mcpu_ctrl_fsm_decode #(.ALU_W(ALU_W)) u_decode (
        .opcode   (bus.OPcode),
        .fun      (bus.Fun),
        .dispatch (dec_dispatch),
        .alu_ctrl (dec_alu),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Only the bus-owning states can stall; every other state advances unconditionally
    assign stalled   = ((state_q == S_IF) || (state_q == S_MRD) || (state_q == S_MWR)) && !bus.MIO_ready;
    assign limit_hit = (WAIT_LIMIT != 0) && stalled && (cnt_q == CNT_LIM);

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        if (stalled) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
        case (state_q)
            S_IF:   if (bus.MIO_ready) state_d = S_ID;
            S_ID: begin
                state_d = dec_dispatch;
                if (dec_illegal) illegal_d = 1'b1;
            end
            S_MADR: state_d = (bus.OPcode == OP_SW) ? S_MWR : S_MRD;
            S_MRD:  if (bus.MIO_ready) state_d = S_MWB;
            S_MWR:  if (bus.MIO_ready) state_d = S_IF;
            S_REX:  state_d = S_RWB;
            S_IEX:  state_d = S_IWB;
            S_MWB, S_RWB, S_IWB, S_LUI,
            S_BR, S_JMP, S_JR, S_JAL: state_d = S_IF;
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        if (limit_hit) begin
            state_d   = S_TRAP;
            bus_err_d = 1'b1;
            cnt_d     = '0;
        end
    end

    logic             pc_write, iord, mem_read, mem_w, ir_write, reg_write, src_a, cpu_mio;
    logic [1:0]       reg_dst, dtr, src_b, pc_src;
    logic [ALU_W-1:0] alu;

    always_comb begin
        pc_write  = 1'b0;
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_w     = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        src_a     = 1'b0;
        cpu_mio   = 1'b0;
        reg_dst   = REGDST_RT;
        dtr       = DTR_ALUOUT;
        src_b     = SRCB_RT;
        pc_src    = PCSRC_ALU;
        alu       = '0;
        case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                cpu_mio  = 1'b1;
                src_b    = SRCB_FOUR;
                alu      = ALU_W'(ALU_ADD);
                ir_write = bus.MIO_ready;
                pc_write = bus.MIO_ready;
            end
            S_ID: begin
                src_b = SRCB_BRIMM;
                alu   = ALU_W'(ALU_ADD);
            end
            S_MADR: begin
                src_a = 1'b1;
                src_b = SRCB_IMM;
                alu   = ALU_W'(ALU_ADD);
            end
            S_MRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                cpu_mio  = 1'b1;
            end
            S_MWB: begin
                dtr       = DTR_MDR;
                reg_write = 1'b1;
            end
            S_MWR: begin
                mem_w   = 1'b1;
                iord    = 1'b1;
                cpu_mio = 1'b1;
            end
            S_REX: begin
                src_a = 1'b1;
                alu   = dec_alu;
            end
            S_RWB: begin
                reg_dst   = REGDST_RD;
                reg_write = 1'b1;
            end
            S_IEX: begin
                src_a = 1'b1;
                src_b = SRCB_IMM;
                alu   = dec_alu;
            end
            S_IWB:  reg_write = 1'b1;
            S_LUI: begin
                dtr       = DTR_LUI;
                reg_write = 1'b1;
            end
            S_BR: begin
                src_a    = 1'b1;
                alu      = ALU_W'(ALU_SUB);
                pc_src   = PCSRC_ALUOUT;
                pc_write = (bus.OPcode == OP_BNE) ? !bus.zero : bus.zero;
            end
            S_JMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            S_JR: begin
                pc_src   = PCSRC_RS;
                pc_write = 1'b1;
            end
            S_JAL: begin
                // PC already holds the return address (+4 taken in IF)
                dtr       = DTR_PC;
                reg_write = 1'b1;
                pc_write  = 1'b1;
                if (bus.OPcode == OP_JAL) begin
                    reg_dst = REGDST_RA;
                    pc_src  = PCSRC_JUMP;
                end else begin
                    reg_dst = REGDST_RD;
                    pc_src  = PCSRC_RS;
                end
            end
            default: ;
        endcase
    end

    assign bus.PCWrite     = rst_n & pc_write;
    assign bus.IorD        = rst_n & iord;
    assign bus.MemRead     = rst_n & mem_read;
    assign bus.mem_w       = rst_n & mem_w;
    assign bus.IRWrite     = rst_n & ir_write;
    assign bus.RegWrite    = rst_n & reg_write;
    assign bus.ALUSrcA     = rst_n & src_a;
    assign bus.CPU_MIO     = rst_n & cpu_mio;
    assign bus.RegDst      = rst_n ? reg_dst : 2'b00;
    assign bus.DatatoReg   = rst_n ? dtr     : 2'b00;
    assign bus.ALUSrcB     = rst_n ? src_b   : 2'b00;
    assign bus.PCSource    = rst_n ? pc_src  : 2'b00;
    assign bus.ALU_Control = rst_n ? alu     : '0;
    assign bus.illegal     = rst_n & illegal_q;
    assign bus.bus_err     = rst_n & bus_err_q;
    assign bus.state       = rst_n ? state_q : 4'd0;

endmodule
